// File: rtl/ika87ad_pkg.sv
// Shared definitions for the IKA87AD opcode fetch path: prefix bytes, opcode
// pages, special opcodes and the fetch state encoding.
package ika87ad_pkg;

  localparam logic [2:0] PAGE_BASE = 3'd0;
  localparam logic [2:0] PAGE_48   = 3'd1;
  localparam logic [2:0] PAGE_60   = 3'd2;
  localparam logic [2:0] PAGE_64   = 3'd3;
  localparam logic [2:0] PAGE_70   = 3'd4;
  localparam logic [2:0] PAGE_74   = 3'd5;

  localparam logic [7:0] PFX_48 = 8'h48;
  localparam logic [7:0] PFX_60 = 8'h60;
  localparam logic [7:0] PFX_64 = 8'h64;
  localparam logic [7:0] PFX_70 = 8'h70;
  localparam logic [7:0] PFX_74 = 8'h74;

  localparam logic [7:0] OPC_HARDI = 8'h73;
  localparam logic [7:0] OPC_NOP   = 8'h00;

  localparam logic [1:0] LEN_INJ = 2'd0;
  localparam logic [1:0] LEN_ONE = 2'd1;
  localparam logic [1:0] LEN_TWO = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH1 = 2'd1,
    ST_FETCH2 = 2'd2,
    ST_ISSUE  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/ika87ad_prefix_map.sv
// Classifies an instruction byte as a page prefix and returns its page number.
// Purely combinational so the disassembler/trace logic can share it.
module ika87ad_prefix_map
  import ika87ad_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic       o_is_prefix,
  output logic [2:0] o_page
);

  // Byte to {is_prefix, page} lookup.
  always_comb begin
    o_is_prefix = 1'b1;
    o_page      = PAGE_BASE;
    case (i_byte)
      PFX_48:  o_page = PAGE_48;
      PFX_60:  o_page = PAGE_60;
      PFX_64:  o_page = PAGE_64;
      PFX_70:  o_page = PAGE_70;
      PFX_74:  o_page = PAGE_74;
      default: begin
        o_is_prefix = 1'b0;
        o_page      = PAGE_BASE;
      end
    endcase
  end

endmodule

// File: rtl/ika87ad_opfetch.sv
// Opcode fetch and prefix assembler: reads opcode bytes, folds prefixes into a
// page number, injects the hardware-interrupt opcode and applies skip.
module ika87ad_opfetch
  import ika87ad_pkg::*;
(
  input  logic       i_EMUCLK,
  input  logic       i_RST_n,
  input  logic       i_NEXT,
  output logic       o_BUS_RD,
  input  logic       i_BUS_ACK,
  input  logic [7:0] i_BUS_DATA,
  output logic       o_PC_INC,
  input  logic       i_INT_REQ,
  output logic       o_INT_ACK,
  input  logic       i_SKIP_SET,
  output logic [7:0] o_OPCODE,
  output logic [2:0] o_OPCODE_PAGE,
  output logic       o_OP_VALID,
  output logic       o_OP_SKIP,
  output logic [1:0] o_OP_LEN
);

  fetch_state_t r_state;
  logic         r_bus_rd;
  logic         r_pc_inc;
  logic         r_int_ack;
  logic         r_op_valid;
  logic         r_op_skip;
  logic         r_skip;
  logic [7:0]   r_opcode;
  logic [2:0]   r_page;
  logic [2:0]   r_pfx_page;
  logic [1:0]   r_len;

  logic         w_is_prefix;
  logic [2:0]   w_pfx_page;
  logic         w_start;
  logic         w_skip_nxt;
  logic         w_inject;

  ika87ad_prefix_map u_prefix_map (
    .i_byte      (i_BUS_DATA),
    .o_is_prefix (w_is_prefix),
    .o_page      (w_pfx_page)
  );

  // Skip flag as it stands after this edge: set wins over the ISSUE clear, and
  // interrupt injection is held off whenever that value is set.
  assign w_start    = i_NEXT & ((r_state == ST_IDLE) | (r_state == ST_ISSUE));
  assign w_skip_nxt = i_SKIP_SET | (r_skip & (r_state != ST_ISSUE));
  assign w_inject   = i_INT_REQ & ~w_skip_nxt;

  // Fetch sequencer with registered bus, pulse and opcode outputs.
  always_ff @(posedge i_EMUCLK) begin
    if (!i_RST_n) begin
      r_state    <= ST_IDLE;
      r_bus_rd   <= 1'b0;
      r_pc_inc   <= 1'b0;
      r_int_ack  <= 1'b0;
      r_op_valid <= 1'b0;
      r_op_skip  <= 1'b0;
      r_skip     <= 1'b0;
      r_opcode   <= OPC_NOP;
      r_page     <= PAGE_BASE;
      r_pfx_page <= PAGE_BASE;
      r_len      <= LEN_INJ;
    end else begin
      r_pc_inc   <= 1'b0;
      r_int_ack  <= 1'b0;
      r_op_valid <= 1'b0;
      r_skip     <= w_skip_nxt;
      case (r_state)
        ST_IDLE, ST_ISSUE: begin
          if (w_start && w_inject) begin
            r_state    <= ST_ISSUE;
            r_opcode   <= OPC_HARDI;
            r_page     <= PAGE_BASE;
            r_len      <= LEN_INJ;
            r_op_skip  <= 1'b0;
            r_op_valid <= 1'b1;
            r_int_ack  <= 1'b1;
          end else if (w_start) begin
            r_state  <= ST_FETCH1;
            r_bus_rd <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_FETCH1: begin
          if (i_BUS_ACK) begin
            r_pc_inc <= 1'b1;
            if (w_is_prefix) begin
              r_pfx_page <= w_pfx_page;
              r_state    <= ST_FETCH2;
            end else begin
              r_opcode   <= i_BUS_DATA;
              r_page     <= PAGE_BASE;
              r_len      <= LEN_ONE;
              r_op_skip  <= w_skip_nxt;
              r_op_valid <= 1'b1;
              r_bus_rd   <= 1'b0;
              r_state    <= ST_ISSUE;
            end
          end else begin
            r_state <= ST_FETCH1;
          end
        end
        ST_FETCH2: begin
          // The second byte is always the opcode, even if it looks like a prefix.
          if (i_BUS_ACK) begin
            r_pc_inc   <= 1'b1;
            r_opcode   <= i_BUS_DATA;
            r_page     <= r_pfx_page;
            r_len      <= LEN_TWO;
            r_op_skip  <= w_skip_nxt;
            r_op_valid <= 1'b1;
            r_bus_rd   <= 1'b0;
            r_state    <= ST_ISSUE;
          end else begin
            r_state <= ST_FETCH2;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_bus_rd <= 1'b0;
        end
      endcase
    end
  end

  assign o_BUS_RD      = r_bus_rd;
  assign o_PC_INC      = r_pc_inc;
  assign o_INT_ACK     = r_int_ack;
  assign o_OP_VALID    = r_op_valid;
  assign o_OP_SKIP     = r_op_skip;
  assign o_OPCODE      = r_opcode;
  assign o_OPCODE_PAGE = r_page;
  assign o_OP_LEN      = r_len;

endmodule

// File: tb/tb_ika87ad_opfetch.sv
// Scoreboard bench for ika87ad_opfetch: expected issues are queued as the
// stimulus is driven and checked by a monitor whenever o_OP_VALID pulses.
module tb_ika87ad_opfetch;

  typedef struct packed {
    logic [7:0] op;
    logic [2:0] page;
    logic [1:0] len;
    logic       skip;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       next;
  logic       bus_rd;
  logic       bus_ack;
  logic [7:0] bus_data;
  logic       pc_inc;
  logic       int_req;
  logic       int_ack;
  logic       skip_set;
  logic [7:0] opcode;
  logic [2:0] page;
  logic       op_valid;
  logic       op_skip;
  logic [1:0] op_len;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   pc_inc_cnt = 0;
  int   rd_cnt = 0;
  int   valid_cnt = 0;
  int   valid_cyc[$];
  exp_t sb[$];
  exp_t e;

  ika87ad_opfetch dut (
    .i_EMUCLK      (clk),
    .i_RST_n       (rst_n),
    .i_NEXT        (next),
    .o_BUS_RD      (bus_rd),
    .i_BUS_ACK     (bus_ack),
    .i_BUS_DATA    (bus_data),
    .o_PC_INC      (pc_inc),
    .i_INT_REQ     (int_req),
    .o_INT_ACK     (int_ack),
    .i_SKIP_SET    (skip_set),
    .o_OPCODE      (opcode),
    .o_OPCODE_PAGE (page),
    .o_OP_VALID    (op_valid),
    .o_OP_SKIP     (op_skip),
    .o_OP_LEN      (op_len)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Monitor: counts pulses and checks every issued opcode against the scoreboard.
  always @(negedge clk) begin
    if (pc_inc) pc_inc_cnt++;
    if (bus_rd) rd_cnt++;
    if (op_valid) begin
      valid_cnt++;
      valid_cyc.push_back(cyc);
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_issue: got op=%02h page=%0d len=%0d, required no issue", opcode, page, op_len);
      end else begin
        e = sb.pop_front();
        if ({opcode, page, op_len, op_skip, int_ack} !== {e.op, e.page, e.len, e.skip, (e.len == 2'd0)}) begin
          n_err++;
          $display("FAIL issue: got op=%02h page=%0d len=%0d skip=%b ack=%b, required op=%02h page=%0d len=%0d skip=%b ack=%b",
                   opcode, page, op_len, op_skip, int_ack, e.op, e.page, e.len, e.skip, (e.len == 2'd0));
        end
      end
    end else if (int_ack) begin
      n_cmp++;
      n_err++;
      $display("FAIL int_ack_alone: got int_ack=1 without op_valid, required 0");
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_next();
    next = 1'b1;
    cycle();
    next = 1'b0;
  endtask

  task automatic wait_rd();
    int n = 0;
    while (!bus_rd && n < 20) begin
      cycle();
      n++;
    end
    if (!bus_rd) begin
      n_cmp++;
      n_err++;
      $display("FAIL bus_rd_timeout: got bus_rd=0, required 1 within 20 cycles");
    end
  endtask

  task automatic serve(input logic [7:0] d);
    wait_rd();
    bus_data = d;
    bus_ack  = 1'b1;
    cycle();
    bus_ack  = 1'b0;
    bus_data = 8'h00;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      cycle();
      n++;
    end
    cycle();
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending issues, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    int p0;
    rst_n = 1'b0; next = 1'b0; bus_ack = 1'b0; bus_data = 8'h00;
    int_req = 1'b0; skip_set = 1'b0;
    repeat (3) cycle();
    n_cmp++;
    if ({bus_rd, pc_inc, int_ack, op_valid, op_skip} !== 5'b00000) begin
      n_err++;
      $display("FAIL reset_pulses: got %b, required 00000", {bus_rd, pc_inc, int_ack, op_valid, op_skip});
    end
    n_cmp++;
    if ({opcode, page, op_len} !== 13'h0) begin
      n_err++;
      $display("FAIL reset_opcode: got op=%02h page=%0d len=%0d, required 00/0/0", opcode, page, op_len);
    end
    rst_n = 1'b1;
    cycle();
    // A stray ACK while idle must not move the PC.
    p0 = pc_inc_cnt;
    bus_ack = 1'b1; bus_data = 8'h54;
    cycle();
    bus_ack = 1'b0;
    repeat (2) cycle();
    n_cmp++;
    if (pc_inc_cnt != p0 || bus_rd !== 1'b0) begin
      n_err++;
      $display("FAIL idle_ack: got pc_inc=%0d bus_rd=%b, required 0/0", pc_inc_cnt - p0, bus_rd);
    end
  endtask

  task automatic test_unprefixed();
    logic [7:0] bytes [3];
    int p0;
    bytes[0] = 8'h54; bytes[1] = 8'h49; bytes[2] = 8'h71;
    for (int i = 0; i < 3; i++) begin
      p0 = pc_inc_cnt;
      sb.push_back('{op: bytes[i], page: 3'd0, len: 2'd1, skip: 1'b0});
      pulse_next();
      serve(bytes[i]);
      drain();
      n_cmp++;
      if (pc_inc_cnt - p0 != 1) begin
        n_err++;
        $display("FAIL unpfx_pc_inc: got %0d, required 1", pc_inc_cnt - p0);
      end
    end
    repeat (3) cycle();
    n_cmp++;
    if ({opcode, page, op_len} !== {8'h71, 3'd0, 2'd1}) begin
      n_err++;
      $display("FAIL hold: got op=%02h page=%0d len=%0d, required 71/0/1", opcode, page, op_len);
    end
  endtask

  task automatic test_prefixed_waits();
    logic [7:0] bytes [2];
    int p0;
    int held;
    bytes[0] = 8'h70; bytes[1] = 8'h68;
    p0 = pc_inc_cnt;
    held = 0;
    sb.push_back('{op: 8'h68, page: 3'd4, len: 2'd2, skip: 1'b0});
    pulse_next();
    for (int b = 0; b < 2; b++) begin
      wait_rd();
      for (int w = 0; w < 3; w++) begin
        if (bus_rd === 1'b1) held++;
        cycle();
      end
      serve(bytes[b]);
    end
    drain();
    n_cmp++;
    if (held != 6) begin
      n_err++;
      $display("FAIL wait_bus_rd: got %0d held cycles, required 6", held);
    end
    n_cmp++;
    if (pc_inc_cnt - p0 != 2) begin
      n_err++;
      $display("FAIL pfx_pc_inc: got %0d, required 2", pc_inc_cnt - p0);
    end
  endtask

  task automatic test_prefix_pages();
    logic [7:0] pfx [5];
    logic [2:0] pg [5];
    pfx[0] = 8'h48; pfx[1] = 8'h60; pfx[2] = 8'h64; pfx[3] = 8'h74; pfx[4] = 8'h60;
    pg[0]  = 3'd1;  pg[1]  = 3'd2;  pg[2]  = 3'd3;  pg[3]  = 3'd5;  pg[4]  = 3'd2;
    for (int i = 0; i < 5; i++) begin
      // The last entry sends 0x60 twice: the second byte stays the opcode.
      sb.push_back('{op: (i == 4) ? 8'h60 : (8'h20 + 8'(i)), page: pg[i], len: 2'd2, skip: 1'b0});
      pulse_next();
      serve(pfx[i]);
      serve((i == 4) ? 8'h60 : (8'h20 + 8'(i)));
      drain();
    end
  endtask

  task automatic test_interrupt();
    int r0;
    r0 = rd_cnt;
    int_req = 1'b1;
    sb.push_back('{op: 8'h73, page: 3'd0, len: 2'd0, skip: 1'b0});
    pulse_next();
    int_req = 1'b0;
    n_cmp++;
    if ({op_valid, int_ack} !== 2'b11) begin
      n_err++;
      $display("FAIL int_latency: got valid/ack=%b, required 11", {op_valid, int_ack});
    end
    drain();
    n_cmp++;
    if (rd_cnt != r0) begin
      n_err++;
      $display("FAIL int_no_read: got %0d bus_rd cycles, required 0", rd_cnt - r0);
    end
  endtask

  task automatic test_skip_deferral();
    skip_set = 1'b1;
    cycle();
    skip_set = 1'b0;
    int_req = 1'b1;
    sb.push_back('{op: 8'h1A, page: 3'd0, len: 2'd1, skip: 1'b1});
    pulse_next();
    n_cmp++;
    if (bus_rd !== 1'b1) begin
      n_err++;
      $display("FAIL skip_fetch: got bus_rd=%b, required 1", bus_rd);
    end
    serve(8'h1A);
    drain();
    sb.push_back('{op: 8'h73, page: 3'd0, len: 2'd0, skip: 1'b0});
    pulse_next();
    int_req = 1'b0;
    drain();
  endtask

  task automatic test_back_to_back();
    int v0;
    v0 = valid_cyc.size();
    sb.push_back('{op: 8'h11, page: 3'd0, len: 2'd1, skip: 1'b0});
    sb.push_back('{op: 8'h22, page: 3'd0, len: 2'd1, skip: 1'b0});
    sb.push_back('{op: 8'h33, page: 3'd0, len: 2'd1, skip: 1'b0});
    next = 1'b1;
    cycle();
    serve(8'h11);
    serve(8'h22);
    wait_rd();
    next = 1'b0;
    serve(8'h33);
    drain();
    n_cmp++;
    if (valid_cyc.size() - v0 != 3 || valid_cyc[v0 + 1] - valid_cyc[v0] != 2) begin
      n_err++;
      $display("FAIL b2b_rate: got %0d issues, required 3 issues 2 cycles apart", valid_cyc.size() - v0);
    end
  endtask

  task automatic test_reset_mid_fetch();
    int v0;
    pulse_next();
    serve(8'h48);
    n_cmp++;
    if (bus_rd !== 1'b1) begin
      n_err++;
      $display("FAIL fetch2_rd: got bus_rd=%b, required 1", bus_rd);
    end
    v0 = valid_cnt;
    rst_n = 1'b0;
    cycle();
    n_cmp++;
    if (bus_rd !== 1'b0) begin
      n_err++;
      $display("FAIL abort_rd: got bus_rd=%b, required 0", bus_rd);
    end
    rst_n = 1'b1;
    bus_data = 8'h55; bus_ack = 1'b1;
    repeat (3) cycle();
    bus_ack = 1'b0;
    n_cmp++;
    if (valid_cnt != v0) begin
      n_err++;
      $display("FAIL abort_issue: got %0d issues, required 0", valid_cnt - v0);
    end
    sb.push_back('{op: 8'h00, page: 3'd0, len: 2'd1, skip: 1'b0});
    pulse_next();
    serve(8'h00);
    drain();
  endtask

  initial begin
    test_reset();
    test_unprefixed();
    test_prefixed_waits();
    test_prefix_pages();
    test_interrupt();
    test_skip_deferral();
    test_back_to_back();
    test_reset_mid_fetch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ika87ad_opfetch.md
# ika87ad_opfetch

Opcode fetch and prefix assembler for the IKA87AD core. It reads instruction bytes from the bus interface, folds the prefix bytes 0x48/0x60/0x64/0x70/0x74 into a 3-bit opcode page, and injects the hardware-interrupt opcode at instruction boundaries. It also applies the skip condition. Its outputs feed the opcode decoder directly as `OPCODE` and `OPCODE_PAGE`.

## Interface
- No parameters.
- `i_EMUCLK` in 1: core clock; all state changes on the rising edge.
- `i_RST_n` in 1: synchronous, active-low reset.
- `i_NEXT` in 1: microcode sequencer is at an instruction boundary and requests the next opcode.
- `o_BUS_RD` out 1: opcode-byte read request at the current PC.
- `i_BUS_ACK` in 1: read completed; `i_BUS_DATA` is valid this cycle.
- `i_BUS_DATA` in 8: fetched byte.
- `o_PC_INC` out 1: one-cycle pulse per accepted byte; the PC increments.
- `i_INT_REQ` in 1: an enabled hardware interrupt is pending (level).
- `o_INT_ACK` out 1: one-cycle pulse when the interrupt opcode is injected.
- `i_SKIP_SET` in 1: pulse; the following instruction is to be skipped.
- `o_OPCODE` out 8: final opcode byte (the byte after the prefix, if any).
- `o_OPCODE_PAGE` out 3: page number.
  - 0: no prefix.
  - 1: 0x48.
  - 2: 0x60.
  - 3: 0x64.
  - 4: 0x70.
  - 5: 0x74.
- `o_OP_VALID` out 1: one-cycle pulse; the opcode and page are valid and held until the next `o_OP_VALID`.
- `o_OP_SKIP` out 1: qualifies `o_OP_VALID`; this instruction is to be executed as skipped.
- `o_OP_LEN` out 2: opcode bytes consumed.
  - 1: no prefix.
  - 2: prefixed.
  - 0: injected.

## Operation
- States:
  - IDLE: waiting for `i_NEXT`.
  - FETCH1: first-byte read.
  - FETCH2: second-byte read after a prefix.
  - ISSUE: one cycle, drives `o_OP_VALID`.
- IDLE + `i_NEXT`:
  - If `i_INT_REQ` is set and the skip flag is clear, go to ISSUE with opcode 0x73, page 0, `o_OP_LEN`=0. Pulse `o_INT_ACK` in that same cycle. No bus read occurs.
  - Otherwise, go to FETCH1.
- FETCH1:
  - `o_BUS_RD`=1.
  - On `i_BUS_ACK`, pulse `o_PC_INC`.
  - If the byte is a prefix, latch its page and go to FETCH2.
  - Otherwise, latch the byte with page 0, `o_OP_LEN`=1, and go to ISSUE.
- FETCH2:
  - `o_BUS_RD`=1.
  - On `i_BUS_ACK`, pulse `o_PC_INC`, latch the byte as the opcode, set `o_OP_LEN`=2, and go to ISSUE.
  - The second byte is never reinterpreted as a prefix. For example, 0x60 0x60 yields page 2, opcode 0x60.
- ISSUE:
  - `o_OP_VALID`=1 and `o_OP_SKIP`=skip flag.
  - The skip flag clears.
  - Next state is IDLE, or FETCH1 directly if `i_NEXT` is high in this cycle. The interrupt check applies the same way as in IDLE.
- Skip flag:
  - Set by `i_SKIP_SET` in any state.
  - Cleared in ISSUE.
  - If `i_SKIP_SET` and ISSUE coincide, set wins: the current instruction reports the old flag value and the flag remains set for the next instruction.
  - While the skip flag is set, interrupt injection is deferred. The skipped instruction is fetched from the bus, never replaced by an interrupt.
- `i_BUS_ACK` outside FETCH1/FETCH2 is ignored and produces no `o_PC_INC`.
- `i_NEXT` outside IDLE/ISSUE is ignored.
- Reset outputs:
  - `o_BUS_RD`, `o_PC_INC`, `o_INT_ACK`, `o_OP_VALID`, `o_OP_SKIP` = 0.
  - `o_OPCODE`=0x00 (NOP), `o_OPCODE_PAGE`=0, `o_OP_LEN`=0.
  - State = IDLE, skip flag = 0.
- Reset asserted mid-fetch aborts the fetch: `o_BUS_RD` drops on the next edge and no partial opcode is issued.

## Timing
- All outputs are registered-state decodes with no combinational path from `i_BUS_DATA` to outputs.
- `o_BUS_RD` and the FETCH states: `o_BUS_RD` asserts in the cycle after `i_NEXT` is sampled and is held until `i_BUS_ACK`, with any number of wait cycles.
- Minimum latency from `i_NEXT` to `o_OP_VALID`:
  - Unprefixed, zero-wait: 2 cycles after the `i_NEXT` edge.
  - Prefixed: 3 cycles.
  - Interrupt: 1 cycle.
- Back-to-back operation: with `i_NEXT` held high in ISSUE, FETCH1 starts the next cycle, giving one issue per 2 cycles at zero wait.
- `o_OPCODE`, `o_OPCODE_PAGE`, `o_OP_LEN` and `o_OP_SKIP` are stable from `o_OP_VALID` until the next ISSUE.

## Structure
- Shared package `ika87ad_pkg`:
  - Page constants `PAGE_BASE`…`PAGE_74`.
  - Prefix byte constants.
  - `OPC_HARDI` = 8'h73.
  - State enum `fetch_state_t`.
- Sub-module `ika87ad_prefix_map`: combinational byte → {is_prefix, page[2:0]}. It is also reused by the disassembler/trace logic.

## Test plan
- Unprefixed fetch: `i_NEXT`, then ACK with byte 0x54 → `o_OP_VALID` with opcode 0x54, page 0, len 1; exactly one `o_PC_INC`.
- Prefixed fetch with waits: bytes 0x70, 0x68, each ACKed after 3 wait cycles → opcode 0x68, page 4, len 2; two `o_PC_INC` pulses; `o_BUS_RD` held throughout each wait.
- Prefix not re-decoded: bytes 0x60, 0x60 → opcode 0x60, page 2.
- Interrupt injection: `i_INT_REQ`=1 at `i_NEXT` → next cycle `o_OP_VALID` with 0x73, page 0, len 0; `o_INT_ACK` in the same cycle; `o_BUS_RD` never asserted.
- Skip deferral: `i_SKIP_SET`, then `i_NEXT` with `i_INT_REQ`=1 → byte 0x1A is fetched and issued with `o_OP_SKIP`=1. The following `i_NEXT` injects 0x73 with `o_OP_SKIP`=0.
- Reset mid-FETCH2 after 0x48: `o_BUS_RD`=0 the next cycle, no `o_OP_VALID`. A later fetch of 0x00 yields page 0.
